multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port: Clk  input  1  rising-edge clock.
REQ-002 SHALL have port: Clrn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: Op  input  6  opcode field of the instruction register.
REQ-004 SHALL have port: Func  input  6  function field of the instruction register.
REQ-005 SHALL have port: Z  input  1  ALU zero flag, valid in EXE.
REQ-006 SHALL have port: Mrdy  input  1  memory ready, completes the current memory access.
REQ-007 SHALL have ports, all outputs: Mreq 1 memory request; Iord 1 address select (0 PC, 1 ALU result); Wir 1 IR load; Wpc 1 PC load; Pcsrc 2 PC source (00 PC+4, 01 branch target, 10 jump); Wmem 1 memory write; Wreg 1 regfile write; Regrt 1 destination rt (1) or rd (0); Se 1 sign-extend (1) or zero-extend (0); Aluqb 1 ALU B from register (1) or immediate (0); Aluc 2 ALU op (00 add, 01 sub, 10 and, 11 or); Reg2reg 1 writeback from ALU (1) or memory (0); State 3 current state.
REQ-008 SHALL have, under REQ-031 only: Icnt  output  32  retired-instruction count.

Function
REQ-009 SHALL decode: R-type (Op=000000) add 100000, sub 100010, and 100100, or 100101; addi 001000; andi 001100; ori 001101; lw 100011; sw 101011; beq 000100; bne 000101; j 000010.
REQ-010 SHALL implement a Moore FSM: IF=000, ID=001, EXE=010, MEM=011, WB=100; encodings 101-111 return to IF on the next edge with all enables inactive.
REQ-011 IF: SHALL assert Mreq=1 and Iord=0; SHALL stay in IF while Mrdy=0; in the cycle with Mrdy=1, SHALL assert Wir=1, Wpc=1, Pcsrc=00 and go to ID.
REQ-012 ID: j SHALL assert Wpc=1, Pcsrc=10 and go to IF; decoded instructions other than j SHALL go to EXE; undecoded Op/Func SHALL go to IF with no write enable asserted (NOP).
REQ-013 EXE: SHALL drive Aluc/Aluqb/Se per REQ-017..019; beq SHALL assert Wpc=1, Pcsrc=01 iff Z=1; bne iff Z=0; branches then go to IF; lw/sw go to MEM; ALU instructions go to WB.
REQ-014 MEM: SHALL assert Mreq=1, Iord=1, and Wmem=1 for sw; SHALL hold MEM, with these outputs held, while Mrdy=0; on Mrdy=1, sw goes to IF, lw goes to WB.
REQ-015 WB: SHALL assert Wreg=1 for one cycle, Regrt=1 for non-R-type, Reg2reg=0 for lw else 1; SHALL go to IF.
REQ-016 Latency with Mrdy held 1: j 2 cycles, beq/bne 3, ALU and sw 4, lw 5; every Mrdy=0 cycle in IF or MEM adds one cycle.
REQ-017 Aluc SHALL be 00 for add/addi/lw/sw, 01 for sub/beq/bne, 10 for and/andi, 11 for or/ori.
REQ-018 Aluqb SHALL be 1 for R-type, beq and bne, else 0.
REQ-019 Se SHALL be 0 for andi/ori, else 1.
REQ-020 Wpc, Wir, Wmem and Wreg SHALL be 0 in every state/condition not listed above; Wpc SHALL never assert on two consecutive edges for one instruction except IF then ID for j.
REQ-021 Op/Func SHALL be sampled only from ID onward; changes during IF SHALL not affect IF behaviour.
REQ-022 All outputs SHALL be combinational functions of State, Op, Func, Z and Mrdy only.

Reset
REQ-023 Clrn=0 SHALL force State=IF immediately, independent of Clk.
REQ-024 While Clrn=0, all outputs SHALL be 0, including Mreq; Icnt SHALL be 0.
REQ-025 Reset asserted mid-instruction (any state, including MEM with Wmem=1) SHALL abort it with no further write enable asserted.
REQ-026 The first IF after Clrn rises SHALL begin on the next rising Clk edge.

Configuration
REQ-030 Macro MCC_PERF_CNT_EN SHALL control the instruction counter.
REQ-031 Defined: Icnt SHALL increment by 1 on each edge leaving ID for j or NOP, EXE for a branch, MEM for sw, or WB; it SHALL wrap 0xFFFFFFFF to 0.
REQ-032 Undefined: the Icnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then add (Op=0, Func=100000), Mrdy=1 -> States IF,ID,EXE,WB; Aluc=00, Aluqb=1; Wreg=1, Regrt=0, Reg2reg=1 in WB only.
REQ-041 lw (100011), Mrdy=0 for 3 cycles in MEM -> MEM held 4 cycles with Mreq=1, Iord=1, Wmem=0; WB with Reg2reg=0, Regrt=1; 8 cycles total.
REQ-042 beq (000100) with Z=1, then Z=0 -> Wpc=1, Pcsrc=01 in EXE for the first only; bne (000101) -> the opposite.
REQ-043 j (000010) -> ID asserts Wpc=1, Pcsrc=10; next state IF; 2 cycles.
REQ-044 sw with Clrn pulled low mid-MEM (Mrdy=0) -> State=000 and Wmem=0 immediately; no Wreg.
REQ-045 MCC_PERF_CNT_EN defined, Icnt preloaded near 0xFFFFFFFF by running instructions (or forced) -> after retiring at 0xFFFFFFFF, Icnt=0; Op=111111 NOP counts and writes nothing.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB); optional retired-instruction counter under MCC_PERF_CNT_EN.
// Latency: j 2, beq/bne 3, ALU/sw 4, lw 5 cycles; all outputs are combinational from State and inputs.
// Backpressure: Mrdy=0 holds IF or MEM with their outputs unchanged; Clrn=0 forces every output low.
module multi_cycle_ctrl (
   input  logic       Clk,
   input  logic       Clrn,
   input  logic [5:0] Op,
   input  logic [5:0] Func,
   input  logic       Z,
   input  logic       Mrdy,
   output logic       Mreq,
   output logic       Iord,
   output logic       Wir,
   output logic       Wpc,
   output logic [1:0] Pcsrc,
   output logic       Wmem,
   output logic       Wreg,
   output logic       Regrt,
   output logic       Se,
   output logic       Aluqb,
   output logic [1:0] Aluc,
   output logic       Reg2reg,
   output logic [2:0] State
`ifdef MCC_PERF_CNT_EN
   ,
   output logic [31:0] Icnt
`endif
);

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EXE = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100
   } state_t;

   state_t state_q, state_d;

   logic is_r;
   logic i_add, i_sub, i_and, i_or, i_addi, i_andi, i_ori;
   logic i_lw, i_sw, i_beq, i_bne, i_j;
   logic is_alu_r, is_alu, is_br, is_valid, br_taken;

   assign is_r     = (Op == 6'b000000);
   assign i_add    = is_r && (Func == 6'b100000);
   assign i_sub    = is_r && (Func == 6'b100010);
   assign i_and    = is_r && (Func == 6'b100100);
   assign i_or     = is_r && (Func == 6'b100101);
   assign i_addi   = (Op == 6'b001000);
   assign i_andi   = (Op == 6'b001100);
   assign i_ori    = (Op == 6'b001101);
   assign i_lw     = (Op == 6'b100011);
   assign i_sw     = (Op == 6'b101011);
   assign i_beq    = (Op == 6'b000100);
   assign i_bne    = (Op == 6'b000101);
   assign i_j      = (Op == 6'b000010);
   assign is_alu_r = i_add | i_sub | i_and | i_or;
   assign is_alu   = is_alu_r | i_addi | i_andi | i_ori;
   assign is_br    = i_beq | i_bne;
   assign is_valid = is_alu | i_lw | i_sw | is_br | i_j;
   assign br_taken = (i_beq && Z) || (i_bne && !Z);

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) state_q <= S_IF;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_IF;
      Mreq    = 1'b0;
      Iord    = 1'b0;
      Wir     = 1'b0;
      Wpc     = 1'b0;
      Pcsrc   = 2'b00;
      Wmem    = 1'b0;
      Wreg    = 1'b0;
      Regrt   = 1'b0;
      Se      = 1'b0;
      Aluqb   = 1'b0;
      Aluc    = 2'b00;
      Reg2reg = 1'b0;
      State   = state_q;
      case (state_q)
         S_IF: begin
            Mreq = 1'b1;
            if (Mrdy) begin
               Wir     = 1'b1;
               Wpc     = 1'b1;
               state_d = S_ID;
            end else begin
               state_d = S_IF;
            end
         end
         S_ID: begin
            if (i_j) begin
               Wpc   = 1'b1;
               Pcsrc = 2'b10;
            end else if (is_valid) begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            Aluqb = is_alu_r | is_br;
            Se    = !(i_andi || i_ori);
            if (i_sub || is_br)              Aluc = 2'b01;
            else if (i_and || i_andi)        Aluc = 2'b10;
            else if (i_or || i_ori)          Aluc = 2'b11;
            if (is_br && br_taken) begin
               Wpc   = 1'b1;
               Pcsrc = 2'b01;
            end
            if (i_lw || i_sw)                state_d = S_MEM;
            else if (is_alu)                 state_d = S_WB;
         end
         S_MEM: begin
            Mreq = 1'b1;
            Iord = 1'b1;
            Wmem = i_sw;
            if (!Mrdy)                       state_d = S_MEM;
            else if (i_lw)                   state_d = S_WB;
         end
         S_WB: begin
            Wreg    = 1'b1;
            Regrt   = !is_r;
            Reg2reg = !i_lw;
         end
         default: state_d = S_IF;
      endcase
      // Reset must silence outputs even before the async state clear is visible.
      if (!Clrn) begin
         {Mreq, Iord, Wir, Wpc, Pcsrc, Wmem, Wreg, Regrt, Se, Aluqb, Aluc, Reg2reg, State} = '0;
      end
   end

`ifdef MCC_PERF_CNT_EN
   logic retire;
   assign retire = ((state_q == S_ID)  && (i_j || !is_valid)) ||
                   ((state_q == S_EXE) && is_br) ||
                   ((state_q == S_MEM) && Mrdy && i_sw) ||
                   (state_q == S_WB);

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn)       Icnt <= 32'd0;
      else if (retire) Icnt <= Icnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed plus randomized bench for multi_cycle_ctrl against a per-instruction phase model.
module tb_multi_cycle_ctrl;

   logic       Clk = 1'b0;
   logic       Clrn, Z, Mrdy;
   logic [5:0] Op, Func;
   logic       Mreq, Iord, Wir, Wpc, Wmem, Wreg, Regrt, Se, Aluqb, Reg2reg;
   logic [1:0] Pcsrc, Aluc;
   logic [2:0] State;
`ifdef MCC_PERF_CNT_EN
   logic [31:0] Icnt;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] icnt_exp = 32'd0;

   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_ADDI = 4, K_ANDI = 5, K_ORI = 6;
   localparam int K_LW = 7, K_SW = 8, K_BEQ = 9, K_BNE = 10, K_J = 11, K_NOP = 12, K_NOPR = 13;

   multi_cycle_ctrl dut (
      .Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z), .Mrdy(Mrdy),
      .Mreq(Mreq), .Iord(Iord), .Wir(Wir), .Wpc(Wpc), .Pcsrc(Pcsrc), .Wmem(Wmem),
      .Wreg(Wreg), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc),
      .Reg2reg(Reg2reg), .State(State)
`ifdef MCC_PERF_CNT_EN
      , .Icnt(Icnt)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [16:0] obs();
      return {Mreq, Iord, Wir, Wpc, Pcsrc, Wmem, Wreg, Regrt, Se, Aluqb, Aluc, Reg2reg, State};
   endfunction

   function automatic logic [16:0] ev(logic mreq, iord, wir, wpc, logic [1:0] pcsrc,
                                      logic wmem, wreg, regrt, se, aluqb,
                                      logic [1:0] aluc, logic reg2reg, logic [2:0] st);
      return {mreq, iord, wir, wpc, pcsrc, wmem, wreg, regrt, se, aluqb, aluc, reg2reg, st};
   endfunction

   function automatic logic [5:0] k_op(int k);
      case (k)
         K_ADDI: return 6'b001000;
         K_ANDI: return 6'b001100;
         K_ORI:  return 6'b001101;
         K_LW:   return 6'b100011;
         K_SW:   return 6'b101011;
         K_BEQ:  return 6'b000100;
         K_BNE:  return 6'b000101;
         K_J:    return 6'b000010;
         K_NOP:  return 6'b111111;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [5:0] k_func(int k);
      case (k)
         K_ADD:  return 6'b100000;
         K_SUB:  return 6'b100010;
         K_AND:  return 6'b100100;
         K_OR:   return 6'b100101;
         K_NOPR: return 6'b000111;
         default: return 6'($urandom);
      endcase
   endfunction

   // ALU op class straight from the instruction table.
   function automatic logic [1:0] k_aluc(int k);
      case (k)
         K_SUB, K_BEQ, K_BNE: return 2'b01;
         K_AND, K_ANDI:       return 2'b10;
         K_OR, K_ORI:         return 2'b11;
         default:             return 2'b00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [16:0] e);
      vectors++;
      assert (obs() === e)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs(), e);
      end
   endtask

   task automatic check_icnt(input string tag);
`ifdef MCC_PERF_CNT_EN
      vectors++;
      assert (Icnt === icnt_exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, Icnt, icnt_exp);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   task automatic cyc(input string tag, input logic [16:0] e, input logic mrdy);
      Mrdy = mrdy;
      @(negedge Clk);
      check(tag, e);
      @(posedge Clk);
      #1;
   endtask

   // One instruction through its phase list; opcode is garbage during IF.
   task automatic run_instr(input int k, input logic z, input int ifw, input int memw);
      logic       r_type, taken, se, aluqb;
      r_type = (k <= K_OR) || (k == K_NOPR);
      taken  = (k == K_BEQ && z) || (k == K_BNE && !z);
      se     = !(k == K_ANDI || k == K_ORI);
      aluqb  = (k <= K_OR) || (k == K_BEQ) || (k == K_BNE);
      Z      = z;
      for (int i = 0; i < ifw; i++) begin
         Op = 6'($urandom); Func = 6'($urandom);
         cyc("if_wait", ev(1,0,0,0,2'b00,0,0,0,0,0,2'b00,0,3'd0), 1'b0);
      end
      Op = 6'($urandom); Func = 6'($urandom);
      cyc("if_fetch", ev(1,0,1,1,2'b00,0,0,0,0,0,2'b00,0,3'd0), 1'b1);
      Op = k_op(k); Func = k_func(k);
      if (k == K_J) begin
         cyc("id_j", ev(0,0,0,1,2'b10,0,0,0,0,0,2'b00,0,3'd1), 1'($urandom));
      end else begin
         cyc("id", ev(0,0,0,0,2'b00,0,0,0,0,0,2'b00,0,3'd1), 1'($urandom));
         if (k != K_NOP && k != K_NOPR) begin
            cyc("exe", ev(0,0,0,taken,taken ? 2'b01 : 2'b00,0,0,0,se,aluqb,k_aluc(k),0,3'd2),
                1'($urandom));
            if (k == K_LW || k == K_SW) begin
               for (int i = 0; i < memw; i++)
                  cyc("mem_wait", ev(1,1,0,0,2'b00,k == K_SW,0,0,0,0,2'b00,0,3'd3), 1'b0);
               cyc("mem_done", ev(1,1,0,0,2'b00,k == K_SW,0,0,0,0,2'b00,0,3'd3), 1'b1);
            end
            if (k != K_SW && k != K_BEQ && k != K_BNE)
               cyc("wb", ev(0,0,0,0,2'b00,0,1,!r_type,0,0,2'b00,k != K_LW,3'd4), 1'($urandom));
         end
      end
      icnt_exp = icnt_exp + 32'd1;
      check_icnt("icnt");
   endtask

   initial begin
      Clrn = 1'b0; Mrdy = 1'b1; Z = 1'b0; Op = 6'b000010; Func = 6'b100000;
      repeat (2) begin
         @(negedge Clk);
         check("reset_outputs", 17'd0);
      end
      check_icnt("reset_icnt");
      @(posedge Clk); #1;
      Clrn = 1'b1;

      run_instr(K_ADD, 1'b0, 0, 0);
      run_instr(K_LW,  1'b1, 0, 3);
      run_instr(K_BEQ, 1'b1, 0, 0);
      run_instr(K_BEQ, 1'b0, 0, 0);
      run_instr(K_BNE, 1'b1, 0, 0);
      run_instr(K_BNE, 1'b0, 0, 0);
      run_instr(K_J,   1'b0, 0, 0);
      run_instr(K_NOP, 1'b0, 0, 0);
      run_instr(K_SW,  1'b0, 2, 1);
      for (int n = 0; n < 60; n++)
         run_instr(int'($urandom_range(0, 13)), 1'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)));

      // sw aborted by reset while waiting in MEM.
      Z = 1'b0; Op = 6'($urandom); Func = 6'($urandom);
      cyc("abort_if", ev(1,0,1,1,2'b00,0,0,0,0,0,2'b00,0,3'd0), 1'b1);
      Op = k_op(K_SW);
      cyc("abort_id", ev(0,0,0,0,2'b00,0,0,0,0,0,2'b00,0,3'd1), 1'b1);
      cyc("abort_exe", ev(0,0,0,0,2'b00,0,0,0,1,0,2'b00,0,3'd2), 1'b1);
      Mrdy = 1'b0;
      @(negedge Clk);
      check("abort_mem", ev(1,1,0,0,2'b00,1,0,0,0,0,2'b00,0,3'd3));
      #2 Clrn = 1'b0;
      #1 check("abort_immediate", 17'd0);
      icnt_exp = 32'd0;
      check_icnt("abort_icnt");
      Mrdy = 1'b1;
      repeat (2) begin
         @(posedge Clk); #1;
         check("abort_held", 17'd0);
      end
      Clrn = 1'b1;
      run_instr(K_ORI, 1'b1, 1, 0);

`ifdef MCC_PERF_CNT_EN
      force dut.Icnt = 32'hFFFF_FFFE;
      #1 release dut.Icnt;
      icnt_exp = 32'hFFFF_FFFE;
      run_instr(K_J,   1'b0, 0, 0);
      run_instr(K_NOP, 1'b0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
